// File: rtl/alu_decode_stage_pkg.sv
// Shared constants and the decoded-bundle type for the RV32I ALU decode stage.
package alu_decode_stage_pkg;

  localparam int DATA_W = 32;
  localparam int RADDR_W = 5;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SLL  = 3'd1;
  localparam logic [2:0] ALU_SLT  = 3'd2;
  localparam logic [2:0] ALU_SLTU = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SR   = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;
  localparam logic [2:0] ALU_AND  = 3'd7;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [2:0]         op;
    logic               mod;
    logic [RADDR_W-1:0] rd;
    logic               rd_we;
    logic [DATA_W-1:0]  pc;
    logic               illegal;
  } alu_bundle_t;

endpackage

// File: rtl/alu_decode_logic.sv
// Combinational RV32I decode of OP / OP-IMM / LUI / AUIPC into an ALU bundle.
module alu_decode_logic
  import alu_decode_stage_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output alu_bundle_t o_bundle
);

  logic [6:0]  w_opcode;
  logic [6:0]  w_funct7;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic [31:0] w_shamt;

  assign w_opcode = i_instr[6:0];
  assign w_funct7 = i_instr[31:25];
  assign w_funct3 = i_instr[14:12];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_u  = {i_instr[31:12], 12'b0};
  assign w_shamt  = {27'b0, i_instr[24:20]};

  logic w_legal;

  always_comb begin
    o_bundle = '0;
    w_legal  = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        o_bundle.a  = i_rs1_data;
        o_bundle.b  = i_rs2_data;
        o_bundle.op = w_funct3;
        if (w_funct7 == F7_ZERO) begin
          w_legal = 1'b1;
        end else if (w_funct7 == F7_ALT && w_funct3 == ALU_ADD) begin
          w_legal    = 1'b1;
          o_bundle.b = (~i_rs2_data) + 32'd1;
        end else if (w_funct7 == F7_ALT && w_funct3 == ALU_SR) begin
          w_legal      = 1'b1;
          o_bundle.mod = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        o_bundle.a  = i_rs1_data;
        o_bundle.op = w_funct3;
        if (w_funct3 == ALU_SLL) begin
          o_bundle.b = w_shamt;
          w_legal    = (w_funct7 == F7_ZERO);
        end else if (w_funct3 == ALU_SR) begin
          o_bundle.b   = w_shamt;
          o_bundle.mod = i_instr[30];
          w_legal      = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
        end else begin
          o_bundle.b = w_imm_i;
          w_legal    = 1'b1;
        end
      end
      OPC_LUI: begin
        o_bundle.b = w_imm_u;
        w_legal    = 1'b1;
      end
      OPC_AUIPC: begin
        o_bundle.a = i_pc;
        o_bundle.b = w_imm_u;
        w_legal    = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase

    // Illegal encodings still travel down the pipe, but with a neutral payload.
    if (!w_legal) begin
      o_bundle.a   = '0;
      o_bundle.b   = '0;
      o_bundle.op  = ALU_ADD;
      o_bundle.mod = 1'b0;
    end
    o_bundle.rd      = i_instr[11:7];
    o_bundle.rd_we   = w_legal && (i_instr[11:7] != 5'd0);
    o_bundle.pc      = i_pc;
    o_bundle.illegal = !w_legal;
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage: combinational decode captured into an output register plus one
// skid entry, giving full-throughput valid/ready toward execute.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_instr,
  input  logic [XLEN-1:0]       in_pc,
  output logic [REG_ADDR_W-1:0] rs1_addr,
  output logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [2:0]            alu_op,
  output logic                  alu_mod,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  rd_we,
  output logic [XLEN-1:0]       out_pc,
  output logic                  illegal
);

  alu_bundle_t w_dec;
  alu_bundle_t r_out;
  alu_bundle_t r_skid;
  logic        r_out_valid;
  logic        r_skid_valid;
  logic        w_accept;
  logic        w_drain;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  alu_decode_logic u_decode (
    .i_instr    (in_instr),
    .i_pc       (in_pc),
    .i_rs1_data (rs1_data),
    .i_rs2_data (rs2_data),
    .o_bundle   (w_dec)
  );

  assign in_ready = rst_n && !r_skid_valid;
  assign w_accept = in_valid && in_ready;
  assign w_drain  = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_drain) begin
      // Skid is older than anything on the input, so it always wins the slot.
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign alu_a     = r_out.a;
  assign alu_b     = r_out.b;
  assign alu_op    = r_out.op;
  assign alu_mod   = r_out.mod;
  assign rd        = r_out.rd;
  assign rd_we     = r_out.rd_we;
  assign out_pc    = r_out.pc;
  assign illegal   = r_out.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench: queue-based reference of the two-entry stage plus an
// ISA-level decode model, with directed cases and a randomized phase.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic [31:0] alu_a, alu_b, out_pc;
  logic [2:0]  alu_op;
  logic        alu_mod, rd_we, illegal;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mod(alu_mod), .rd(rd),
    .rd_we(rd_we), .out_pc(out_pc), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        mod;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;
  bit   m_acc, m_pop;

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    bit ok;
    opc = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12];
    ok = 1'b0;
    e.a = 0; e.b = 0; e.op = 0; e.mod = 0;
    e.rd = ins[11:7]; e.pc = pc;
    if (opc == 7'h33) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.a = r1; e.op = f3;
      e.b = (f7 == 7'h20 && f3 == 3'd0) ? 32'd0 - r2 : r2;
      e.mod = (f7 == 7'h20 && f3 == 3'd5);
    end else if (opc == 7'h13) begin
      e.a = r1; e.op = f3;
      if (f3 == 3'd1) begin
        ok = (f7 == 7'h00); e.b = 32'(ins[24:20]);
      end else if (f3 == 3'd5) begin
        ok = (f7 == 7'h00 || f7 == 7'h20); e.b = 32'(ins[24:20]); e.mod = ins[30];
      end else begin
        ok = 1'b1; e.b = 32'($signed(ins) >>> 20);
      end
    end else if (opc == 7'h37) begin
      ok = 1'b1; e.b = ins & 32'hFFFFF000;
    end else if (opc == 7'h17) begin
      ok = 1'b1; e.a = pc; e.b = ins & 32'hFFFFF000;
    end
    if (!ok) begin
      e.a = 0; e.b = 0; e.op = 0; e.mod = 0;
    end
    e.ill = !ok;
    e.we = ok && (e.rd != 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference bookkeeping: the stage holds at most two bundles, in order.
  always @(posedge clk) begin
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_pop = (q.size() > 0) && out_ready;
      if (m_pop) void'(q.pop_front());
      if (m_acc) q.push_back(model(in_instr, in_pc, rs1_data, rs2_data));
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready", 32'(in_ready), 32'(rst_n && (q.size() < 2)));
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("rs1_addr", 32'(rs1_addr), 32'(in_instr[19:15]));
      check("rs2_addr", 32'(rs2_addr), 32'(in_instr[24:20]));
      if (q.size() > 0 && out_valid === 1'b1) begin
        check("alu_a", alu_a, q[0].a);
        check("alu_b", alu_b, q[0].b);
        check("alu_op", 32'(alu_op), 32'(q[0].op));
        check("alu_mod", 32'(alu_mod), 32'(q[0].mod));
        check("rd", 32'(rd), 32'(q[0].rd));
        check("rd_we", 32'(rd_we), 32'(q[0].we));
        check("out_pc", out_pc, q[0].pc);
        check("illegal", 32'(illegal), 32'(q[0].ill));
      end
    end
  end

  task automatic chk_out(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic mod, input logic [4:0] r,
                         input logic we, input logic ill);
    check({name, ".valid"}, 32'(out_valid), 32'd1);
    check({name, ".a"}, alu_a, a);
    check({name, ".b"}, alu_b, b);
    check({name, ".op"}, 32'(alu_op), 32'(op));
    check({name, ".mod"}, 32'(alu_mod), 32'(mod));
    check({name, ".rd"}, 32'(rd), 32'(r));
    check({name, ".we"}, 32'(rd_we), 32'(we));
    check({name, ".ill"}, 32'(illegal), 32'(ill));
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v; in_instr = ins; in_pc = pc; rs1_data = r1; rs2_data = r2;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    drive(1'b1, ins, pc, r1, r2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  f7s [3];
    w = $urandom;
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'($urandom);
    case ($urandom_range(0, 5))
      0: begin w[6:0] = 7'h33; w[31:25] = f7s[$urandom_range(0, 2)]; end
      1: w[6:0] = 7'h13;
      2: begin w[6:0] = 7'h13; w[14:12] = ($urandom % 2) ? 3'd1 : 3'd5;
               w[31:25] = f7s[$urandom_range(0, 2)]; end
      3: w[6:0] = 7'h37;
      4: w[6:0] = 7'h17;
      default: ;
    endcase
    return w;
  endfunction

  exp_t pin;

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

    pin = model(32'h402081B3, 0, 9, 1);
    check("model_sub_b", pin.b, 32'hFFFFFFFF);
    pin = model(32'h4030D213, 0, 4, 0);
    check("model_srai", {pin.b[28:0], pin.op}, {29'd3, 3'd5});
    pin = model(32'h12345297, 32'h100, 0, 0);
    check("model_auipc", pin.a ^ pin.b, 32'h100 ^ 32'h12345000);
    pin = model(32'h00000073, 0, 1, 2);
    check("model_ill", {31'd0, pin.ill}, 32'd1);

    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.zero", alu_a | alu_b | out_pc | 32'(alu_op) | 32'(rd), 32'd0);
    check("rst.flags", 32'({alu_mod, rd_we, illegal}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.in_ready", 32'(in_ready), 32'd1);

    @(posedge clk); #1;
    send(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk_out("add", 5, 7, 0, 0, 3, 1, 0);
    @(posedge clk); #1;
    send(32'h402081B3, 32'h4, 32'd9, 32'd1);
    chk_out("sub", 9, 32'hFFFFFFFF, 0, 0, 3, 1, 0);
    @(posedge clk); #1;
    send(32'h4030D213, 32'h8, 32'h80000000, 32'd0);
    chk_out("srai", 32'h80000000, 3, 5, 1, 4, 1, 0);
    @(posedge clk); #1;
    send(32'h12345297, 32'h100, 32'd0, 32'd0);
    chk_out("auipc", 32'h100, 32'h12345000, 0, 0, 5, 1, 0);
    check("auipc.pc", out_pc, 32'h100);
    @(posedge clk); #1;
    send(32'h00100013, 32'h104, 32'd0, 32'd0);
    chk_out("addi_x0", 0, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    send(32'h00000073, 32'h108, 32'd3, 32'd4);
    chk_out("ecall", 0, 0, 0, 0, 0, 0, 1);

    // Stall: two accepted, third held off.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h200, 32'd1, 32'd2);
    @(posedge clk); #1;
    drive(1'b1, 32'h402081B3, 32'h204, 32'd10, 32'd3);
    @(posedge clk); #1;
    drive(1'b1, 32'h12345297, 32'h208, 32'd0, 32'd0);
    @(negedge clk);
    check("stall.in_ready", 32'(in_ready), 32'd0);
    chk_out("stall.first", 1, 2, 0, 0, 3, 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk_out("stall.first_held", 1, 2, 0, 0, 3, 1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_out("stall.second", 10, 32'hFFFFFFFD, 0, 0, 3, 1, 0);
    check("stall.in_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall.drained", 32'(out_valid), 32'd0);

    // Flush with both entries full and a same-cycle offer.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h300, 32'd1, 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 32'h002081B3, 32'h304, 32'd2, 32'd2);
    @(posedge clk); #1;
    drive(1'b1, 32'h00100013, 32'h308, 32'd3, 32'd3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush.out_valid", 32'(out_valid), 32'd0);
    check("flush.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush.nothing", 32'(out_valid), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      drive(($urandom % 4) != 0, gen_instr(), $urandom, $urandom, $urandom);
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 40) == 0;
      rst_n = ($urandom % 500) != 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("end.empty", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
